alu_arbiter: RTL and testbench

Shares one instance of the team's 4-bit combinational ALU (`alu`: A, B, ALU_Sel → Result, Carry) between two independent requesters.
- Each requester presents operands and an opcode on a valid/ready channel.
- A round-robin FSM grants one request at a time and drives the shared ALU from registered operands.
- The result comes back on a single tagged response channel with valid/ready backpressure.

---
 rtl/alu_arbiter_pkg.sv | 27 ++
 rtl/alu_arbiter_if.sv | 42 ++++
 rtl/alu.sv | 30 +++
 rtl/alu_rr_grant.sv | 13 +
 rtl/alu_arbiter.sv | 118 +++++++++++
 tb/tb_alu_arbiter.sv | 230 +++++++++++++++++++++++
 6 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter slice.
// Contents: opcode constants, opcode field width, default datapath width,
// FSM state encoding and an illegal-opcode helper.
package alu_arbiter_pkg;

  localparam int unsigned ALU_SEL_W = 3;
  localparam int unsigned ALU_WIDTH = 4;

  localparam logic [ALU_SEL_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_SEL_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_SEL_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_SEL_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALU_SEL_W-1:0] ALU_XOR = 3'b100;
  localparam logic [ALU_SEL_W-1:0] ALU_NOT = 3'b101;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

  // 110 and 111 have no ALU meaning.
  function automatic logic sel_illegal(input logic [ALU_SEL_W-1:0] sel);
    return sel[2] & sel[1];
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of the two request channels, the tagged response channel and busy.
// master: requesters/consumer side (drives req*_valid/payload, rsp_ready).
// slave:  the arbiter (drives req*_ready, rsp_*, busy).
interface alu_arbiter_if
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
);
  logic                 req0_valid;
  logic                 req0_ready;
  logic [WIDTH-1:0]     req0_a;
  logic [WIDTH-1:0]     req0_b;
  logic [ALU_SEL_W-1:0] req0_sel;
  logic                 req1_valid;
  logic                 req1_ready;
  logic [WIDTH-1:0]     req1_a;
  logic [WIDTH-1:0]     req1_b;
  logic [ALU_SEL_W-1:0] req1_sel;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic                 rsp_id;
  logic [WIDTH-1:0]     rsp_result;
  logic                 rsp_carry;
  logic                 rsp_err;
  logic                 busy;

  modport master (
    output req0_valid, req0_a, req0_b, req0_sel,
    output req1_valid, req1_a, req1_b, req1_sel,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_err, busy
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sel,
    input  req1_valid, req1_a, req1_b, req1_sel,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_err, busy
  );
endinterface

// File: rtl/alu.sv
// Shared 4-bit combinational ALU.
// Ports: A, B operands; ALU_Sel opcode; Result WIDTH bits; Carry is the
// carry-out of ADD / borrow of SUB, zero for logic ops and unused opcodes.
module alu #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALU_Sel,
  output logic [WIDTH-1:0] Result,
  output logic             Carry
);
  logic [WIDTH:0] tmp;

  always_comb begin
    tmp = '0;
    case (ALU_Sel)
      3'b000:  tmp = {1'b0, A} + {1'b0, B};
      3'b001:  tmp = {1'b0, A} - {1'b0, B};
      3'b010:  tmp = {1'b0, A & B};
      3'b011:  tmp = {1'b0, A | B};
      3'b100:  tmp = {1'b0, A ^ B};
      3'b101:  tmp = {1'b0, ~A};
      default: tmp = '0;
    endcase
  end

  assign Result = tmp[WIDTH-1:0];
  assign Carry  = tmp[WIDTH];
endmodule

// File: rtl/alu_rr_grant.sv
// Two-way round-robin grant, purely combinational.
// Ports: valid0/valid1 requests; rr_ptr selects the winner on a tie;
// grant0/grant1 one-hot (or zero) grant.
module alu_rr_grant (
  input  logic valid0,
  input  logic valid1,
  input  logic rr_ptr,
  output logic grant0,
  output logic grant1
);
  assign grant0 = valid0 & (~valid1 | ~rr_ptr);
  assign grant1 = valid1 & (~valid0 |  rr_ptr);
endmodule

// File: rtl/alu_arbiter.sv
// Time-shares one ALU between two requesters with round-robin arbitration.
// Ports: clk, rst_n (synchronous, active-low); bus (slave modport) carries
// both request channels, the tagged response channel and busy.
// Flow: IDLE accepts one request into operand registers, EXEC registers
// the ALU output, RESP holds the response until rsp_ready.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned NREQ  = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);
  localparam int unsigned IdW = $clog2(NREQ);

  state_e               state_q, state_d;
  logic                 rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]     op_a_q, op_b_q;
  logic [ALU_SEL_W-1:0] op_sel_q;
  logic [IdW-1:0]       op_id_q;
  logic [IdW-1:0]       rsp_id_q;
  logic [WIDTH-1:0]     rsp_result_q;
  logic                 rsp_carry_q, rsp_err_q;

  logic             grant0, grant1, accept0, accept1, idle;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;

  alu_rr_grant u_grant (
    .valid0 (bus.req0_valid),
    .valid1 (bus.req1_valid),
    .rr_ptr (rr_ptr_q),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  // Operands come only from registers so the ALU never sees live port data.
  alu #(.WIDTH(WIDTH)) u_alu (
    .A       (op_a_q),
    .B       (op_b_q),
    .ALU_Sel (op_sel_q),
    .Result  (alu_result),
    .Carry   (alu_carry)
  );

  // Ready is held low during reset regardless of the registered state.
  assign idle           = rst_n & (state_q == StIdle);
  assign bus.req0_ready = idle & grant0;
  assign bus.req1_ready = idle & grant1;
  assign accept0        = bus.req0_valid & bus.req0_ready;
  assign accept1        = bus.req1_valid & bus.req1_ready;

  assign bus.rsp_valid  = (state_q == StResp);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_carry  = rsp_carry_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.busy       = rst_n & (state_q != StIdle);

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      StIdle: if (accept0 || accept1) state_d = StExec;
      StExec: state_d = StResp;
      StResp: begin
        if (bus.rsp_ready) begin
          state_d  = StIdle;
          rr_ptr_d = ~rsp_id_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      rr_ptr_q     <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_sel_q     <= '0;
      op_id_q      <= '0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      if (accept0) begin
        op_a_q   <= bus.req0_a;
        op_b_q   <= bus.req0_b;
        op_sel_q <= bus.req0_sel;
        op_id_q  <= 1'b0;
      end else if (accept1) begin
        op_a_q   <= bus.req1_a;
        op_b_q   <= bus.req1_b;
        op_sel_q <= bus.req1_sel;
        op_id_q  <= 1'b1;
      end
      if (state_q == StExec) begin
        rsp_id_q <= op_id_q;
        if (sel_illegal(op_sel_q)) begin
          rsp_result_q <= '0;
          rsp_carry_q  <= 1'b0;
          rsp_err_q    <= 1'b1;
        end else begin
          rsp_result_q <= alu_result;
          rsp_carry_q  <= alu_carry;
          rsp_err_q    <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  typedef struct packed {
    logic       id;
    logic [3:0] result;
    logic       carry;
    logic       err;
  } rsp_t;

  typedef struct packed {
    logic       id;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] sel;
    rsp_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(4)) bus ();

  alu_arbiter #(.WIDTH(4), .NREQ(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   errors = 0;
  int   checks = 0;
  rsp_t sb_q[$];
  rsp_t pend0, pend1;
  logic id_log[$];
  int   rsp_count = 0;
  vec_t tbl[10];

  function automatic vec_t mk(input logic id, input logic [3:0] a, input logic [3:0] b,
                              input logic [2:0] sel, input logic [3:0] r, input logic c,
                              input logic e);
    vec_t v;
    v.id = id; v.a = a; v.b = b; v.sel = sel;
    v.exp.id = id; v.exp.result = r; v.exp.carry = c; v.exp.err = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: push on accept, pop and compare on response handshake.
  always @(negedge clk) begin : monitor
    rsp_t got;
    rsp_t exp_r;
    if (rst_n) begin
      if (bus.req0_valid && bus.req0_ready) sb_q.push_back(pend0);
      if (bus.req1_valid && bus.req1_ready) sb_q.push_back(pend1);
      if (bus.rsp_valid && bus.rsp_ready) begin
        rsp_count++;
        id_log.push_back(bus.rsp_id);
        got = {bus.rsp_id, bus.rsp_result, bus.rsp_carry, bus.rsp_err};
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got %0h expected none", got);
        end else begin
          exp_r = sb_q.pop_front();
          check("rsp{id,res,c,err}", 32'(got), 32'(exp_r));
        end
      end
    end
  end

  task automatic issue(input vec_t v);
    logic ok;
    if (v.id == 1'b0) begin
      pend0 = v.exp;
      bus.req0_a = v.a; bus.req0_b = v.b; bus.req0_sel = v.sel; bus.req0_valid = 1'b1;
    end else begin
      pend1 = v.exp;
      bus.req1_a = v.a; bus.req1_b = v.b; bus.req1_sel = v.sel; bus.req1_valid = 1'b1;
    end
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = v.id ? bus.req1_ready : bus.req0_ready;
    end
    check("req_accept", 32'(ok), 32'd1);
    @(posedge clk); #1;
    if (v.id == 1'b0) bus.req0_valid = 1'b0;
    else bus.req1_valid = 1'b0;
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk); #2;
      done = (sb_q.size() == 0) && !bus.busy;
    end
    check("drain", 32'(done), 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic seen;
    tbl[0] = mk(1'b1, 4'hF, 4'h1, ALU_ADD, 4'h0, 1'b1, 1'b0);
    tbl[1] = mk(1'b0, 4'h7, 4'h2, ALU_SUB, 4'h5, 1'b0, 1'b0);
    tbl[2] = mk(1'b1, 4'h5, 4'h3, ALU_AND, 4'h1, 1'b0, 1'b0);
    tbl[3] = mk(1'b0, 4'h5, 4'h3, ALU_OR,  4'h7, 1'b0, 1'b0);
    tbl[4] = mk(1'b1, 4'h5, 4'h3, ALU_XOR, 4'h6, 1'b0, 1'b0);
    tbl[5] = mk(1'b0, 4'h5, 4'h0, ALU_NOT, 4'hA, 1'b0, 1'b0);
    tbl[6] = mk(1'b1, 4'h9, 4'h8, ALU_ADD, 4'h1, 1'b1, 1'b0);
    tbl[7] = mk(1'b1, 4'hF, 4'hF, 3'b110,  4'h0, 1'b0, 1'b1);
    tbl[8] = mk(1'b1, 4'h2, 4'h3, ALU_ADD, 4'h5, 1'b0, 1'b0);
    tbl[9] = mk(1'b0, 4'h3, 4'h3, 3'b111,  4'h0, 1'b0, 1'b1);

    bus.req0_valid = 1'b1; bus.req0_a = 4'h0; bus.req0_b = 4'h0; bus.req0_sel = 3'b000;
    bus.req1_valid = 1'b0; bus.req1_a = 4'h0; bus.req1_b = 4'h0; bus.req1_sel = 3'b000;
    bus.rsp_ready  = 1'b1;
    pend0 = '0; pend1 = '0;

    // Reset state, with a valid pending to prove ready stays low.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
    check("rst_rsp_fields", 32'({bus.rsp_id, bus.rsp_result, bus.rsp_carry, bus.rsp_err}),
          32'd0);
    bus.req0_valid = 1'b0;
    rst_n = 1'b1;

    // Single ADD with latency checks.
    issue(mk(1'b0, 4'h5, 4'h3, ALU_ADD, 4'h8, 1'b0, 1'b0));
    check("lat_exec_valid", 32'(bus.rsp_valid), 32'd0);
    check("lat_exec_busy", 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    check("lat_resp_valid", 32'(bus.rsp_valid), 32'd1);
    check("lat_resp_result", 32'(bus.rsp_result), 32'h8);
    drain();

    for (int i = 0; i < 10; i++) begin
      issue(tbl[i]);
      drain();
    end

    // Fairness: both continuously valid from a fresh reset.
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    pend0 = mk(1'b0, 4'h5, 4'h3, ALU_AND, 4'h1, 1'b0, 1'b0).exp;
    pend1 = mk(1'b1, 4'h5, 4'h3, ALU_XOR, 4'h6, 1'b0, 1'b0).exp;
    bus.req0_a = 4'h5; bus.req0_b = 4'h3; bus.req0_sel = ALU_AND;
    bus.req1_a = 4'h5; bus.req1_b = 4'h3; bus.req1_sel = ALU_XOR;
    id_log.delete();
    rsp_count = 0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    for (int i = 0; i < 100 && rsp_count < 4; i++) begin
      @(negedge clk); #1;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    check("fair_count", 32'(rsp_count), 32'd4);
    drain();
    if (id_log.size() >= 4) begin
      for (int i = 0; i < 4; i++) check($sformatf("fair_id%0d", i), 32'(id_log[i]), 32'(i % 2));
    end

    // Backpressure: OR held in RESP while req1 waits.
    bus.rsp_ready = 1'b0;
    issue(mk(1'b0, 4'h5, 4'h3, ALU_OR, 4'h7, 1'b0, 1'b0));
    pend1 = mk(1'b1, 4'h1, 4'h1, ALU_ADD, 4'h2, 1'b0, 1'b0).exp;
    bus.req1_a = 4'h1; bus.req1_b = 4'h1; bus.req1_sel = ALU_ADD; bus.req1_valid = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_result", 32'(bus.rsp_result), 32'h7);
      check("bp_readys", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
      check("bp_busy", 32'(bus.busy), 32'd1);
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 32'(bus.rsp_valid), 32'd0);
    check("bp_release_ready1", 32'(bus.req1_ready), 32'd1);
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    drain();

    // Reset while EXEC: operation dropped, no response.
    issue(mk(1'b0, 4'h6, 4'h1, ALU_ADD, 4'h7, 1'b0, 1'b0));
    rst_n = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    @(posedge clk); #1;
    sb_q.delete();
    check("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_readys", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_grant", 32'({bus.req0_ready, bus.req1_ready}), 32'b10);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      seen = seen | bus.rsp_valid;
    end
    check("dropped_no_rsp", 32'(seen), 32'd0);
    issue(mk(1'b0, 4'h2, 4'h2, ALU_ADD, 4'h4, 1'b0, 1'b0));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
